// File: rtl/axi_ic_pkg.sv
// Shared types and constants for the 4-master AXI interconnect arbiters.
// Imported by the read-channel arbiter and by the round-robin picker.
package axi_ic_pkg;

  localparam int NUM_MASTERS = 4;
  localparam int GRANT_W     = NUM_MASTERS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  function automatic logic [GRANT_W-1:0] onehot_grant(input logic [1:0] idx);
    logic [GRANT_W-1:0] g;
    g      = '0;
    g[idx] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/axi_read_arbiter_if.sv
// Request, slave-side handshake and grant signals of the read-channel arbiter.
// The master modport is the arbiter itself (it drives the grants); slave is the bus side.
interface axi_read_arbiter_if #(
  parameter int LEN_WIDTH = 8
);

  logic                 s0_ARVALID;
  logic                 s1_ARVALID;
  logic                 s2_ARVALID;
  logic                 s3_ARVALID;
  logic                 s2m_ARVALID;
  logic                 s2m_ARREADY;
  logic [LEN_WIDTH-1:0] s2m_ARLEN;
  logic                 s2m_RVALID;
  logic                 s2m_RREADY;
  logic                 s2m_RLAST;
  logic                 s0_rgrnt;
  logic                 s1_rgrnt;
  logic                 s2_rgrnt;
  logic                 s3_rgrnt;
  logic [1:0]           rgrnt_id;
  logic                 rd_busy;
  logic                 rlast_err;

  modport master (
    input  s0_ARVALID, s1_ARVALID, s2_ARVALID, s3_ARVALID,
    input  s2m_ARVALID, s2m_ARREADY, s2m_ARLEN,
    input  s2m_RVALID, s2m_RREADY, s2m_RLAST,
    output s0_rgrnt, s1_rgrnt, s2_rgrnt, s3_rgrnt,
    output rgrnt_id, rd_busy, rlast_err
  );

  modport slave (
    output s0_ARVALID, s1_ARVALID, s2_ARVALID, s3_ARVALID,
    output s2m_ARVALID, s2m_ARREADY, s2m_ARLEN,
    output s2m_RVALID, s2m_RREADY, s2m_RLAST,
    input  s0_rgrnt, s1_rgrnt, s2_rgrnt, s3_rgrnt,
    input  rgrnt_id, rd_busy, rlast_err
  );

endinterface

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: searches ptr+1, ptr+2, ptr+3, ptr.
// Shared by the read- and write-channel arbiters.
module rr_pick4
  import axi_ic_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [1:0]             ptr,
  output logic                   valid,
  output logic [1:0]             win
);

  logic [1:0] cand;

  // Walk from lowest to highest priority so the nearest requester overwrites.
  always_comb begin
    valid = 1'b0;
    win   = ptr;
    cand  = ptr;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        valid = 1'b1;
        win   = cand;
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Round-robin read-channel arbiter: holds a one-hot grant from AR acceptance
// through the RLAST beat, one outstanding read, and flags RLAST/ARLEN mismatches.
module axi_read_arbiter
  import axi_ic_pkg::*;
#(
  parameter int          LEN_WIDTH   = 8,
  parameter int unsigned RR_INIT_PTR = 3
)(
  input  logic               clk,
  input  logic               rstn,
  axi_read_arbiter_if.master bus
);

  arb_state_e           state;
  logic [1:0]           ptr;
  logic [LEN_WIDTH-1:0] rem;
  logic [GRANT_W-1:0]   grant;
  logic [1:0]           grant_id;
  logic                 err;

  logic [NUM_MASTERS-1:0] req;
  logic                   pick_valid;
  logic [1:0]             pick_win;
  logic                   ar_fire;
  logic                   beat;

  assign req     = {bus.s3_ARVALID, bus.s2_ARVALID, bus.s1_ARVALID, bus.s0_ARVALID};
  assign ar_fire = bus.s2m_ARVALID & bus.s2m_ARREADY;
  assign beat    = bus.s2m_RVALID & bus.s2m_RREADY;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .win   (pick_win)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      ptr      <= 2'(RR_INIT_PTR);
      rem      <= '0;
      grant    <= '0;
      grant_id <= 2'd0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            grant    <= onehot_grant(pick_win);
            grant_id <= pick_win;
            ptr      <= pick_win;
            state    <= ADDR;
          end
        end
        ADDR: begin
          // A dropped ARVALID from the owner is not recovered here; grant holds.
          if (ar_fire) begin
            rem   <= bus.s2m_ARLEN;
            state <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            if (rem != '0) rem <= rem - LEN_WIDTH'(1);
            if (bus.s2m_RLAST) begin
              err <= (rem != '0);
              // Re-arbitrate on the last beat so the next owner has no idle gap.
              if (pick_valid) begin
                grant    <= onehot_grant(pick_win);
                grant_id <= pick_win;
                ptr      <= pick_win;
                state    <= ADDR;
              end else begin
                grant <= '0;
                state <= IDLE;
              end
            end else if (rem == '0) begin
              err <= 1'b1;
            end
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.s0_rgrnt  = grant[0];
  assign bus.s1_rgrnt  = grant[1];
  assign bus.s2_rgrnt  = grant[2];
  assign bus.s3_rgrnt  = grant[3];
  assign bus.rgrnt_id  = grant_id;
  assign bus.rd_busy   = (state != IDLE);
  assign bus.rlast_err = err;

endmodule
